// File: rtl/rs_dec_ctrl.sv
// rs_dec_ctrl -- sequencing controller for an external RS(7,3) GF(8) decoder.
//
// Codewords are buffered in a 2-entry FIFO, handed one at a time to the
// decoder (dec_enable held for DEC_LATENCY cycles with dec_codeword stable),
// and the decoder's result is captured and offered downstream.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   in_valid/in_ready   upstream codeword handshake (in_codeword, 21 bits)
//   dec_enable          decoder enable, high only while decoding
//   dec_codeword        codeword presented to the decoder (21 bits)
//   dec_decoded         decoder result, 3 symbols x 3 bits
//   out_valid/out_ready downstream message handshake (out_data, 9 bits)
//   busy                high when FSM not idle or FIFO holds entries
//   done_count          delivered message count, wraps 255 -> 0
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. in_ready and out_valid come only from registers,
// so neither in_valid nor out_ready reaches any output combinationally.
// A producer may assert valid while ready is low; nothing is lost and nothing
// is stored until ready is seen high at an edge.

module rs_dec_ctrl #(
  parameter int DEC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] in_codeword,
  output logic        dec_enable,
  output logic [20:0] dec_codeword,
  input  logic [8:0]  dec_decoded,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_data,
  output logic        busy,
  output logic [7:0]  done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(DEC_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;

  // FIFO storage
  logic [20:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [20:0] fifo_head;

  assign fifo_empty = (fifo_count == 2'd0);
  assign fifo_full  = (fifo_count == 2'd2);
  assign fifo_head  = fifo_mem[rd_ptr];

  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  // The FSM takes the head in IDLE, or straight from OUT on a handshake so
  // back-to-back codewords never pass through IDLE.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)                  pop = 1'b1;
      else if (state == OUT && out_ready) pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_codeword;
        wr_ptr           <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (pop && !push) fifo_count <= fifo_count - 2'd1;
    end
  end

  // Controller FSM; all outputs below decode registered state only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      dec_codeword <= '0;
      out_data     <= '0;
      done_count   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            dec_codeword <= fifo_head;
            cnt          <= 4'd0;
            state        <= RUN;
          end
        end
        RUN: begin
          // The decoder result is valid on the last enabled cycle.
          if (cnt == LAST_CNT) begin
            out_data <= dec_decoded;
            state    <= OUT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            done_count <= done_count + 8'd1;
            if (!fifo_empty) begin
              dec_codeword <= fifo_head;
              cnt          <= 4'd0;
              state        <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dec_enable = (state == RUN);
  assign out_valid  = (state == OUT);
  assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rs_dec_ctrl.sv
// tb_rs_dec_ctrl -- directed bench for rs_dec_ctrl.
// The bench acts as the decoder: dec_decoded carries the true message only on
// the last enabled cycle of a decode, and the inverted message otherwise.

module tb_rs_dec_ctrl;

  localparam int L = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_codeword;
  logic        dec_enable;
  logic [20:0] dec_codeword;
  logic [8:0]  dec_decoded;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic        busy;
  logic [7:0]  done_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  localparam logic [20:0] CW_REF = 21'b000001110011001111100;

  rs_dec_ctrl #(.DEC_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
    .dec_enable(dec_enable), .dec_codeword(dec_codeword), .dec_decoded(dec_decoded),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done_count(done_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // decoder model
  function automatic logic [8:0] msg_of(input logic [20:0] cw);
    if (cw == CW_REF) return 9'o061;
    return cw[20:12];
  endfunction

  int en_cnt = 0;
  always @(posedge clk) en_cnt <= dec_enable ? en_cnt + 1 : 0;
  assign dec_decoded = (dec_enable && en_cnt == L - 1) ? msg_of(dec_codeword)
                                                       : ~msg_of(dec_codeword);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({in_ready, dec_enable, out_valid, busy} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags: got %b need 1000", {in_ready, dec_enable, out_valid, busy});
    end
    n_cmp++;
    if ({dec_codeword, out_data, done_count} !== 38'd0) begin
      n_err++; $display("FAIL reset_data: got cw=%h od=%h dc=%0d need 0", dec_codeword, out_data, done_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    in_codeword = CW_REF; in_valid = 1'b1;
    tick();                      // push edge T
    in_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      n_cmp++;
      if (dec_enable !== (k >= 1 && k <= L)) begin
        n_err++; $display("FAIL single_en k=%0d: got %b need %b", k, dec_enable, (k >= 1 && k <= L));
      end
      n_cmp++;
      if (out_valid !== (k >= L + 1)) begin
        n_err++; $display("FAIL single_ov k=%0d: got %b need %b", k, out_valid, (k >= L + 1));
      end
      if (k < 6) tick();
    end
    n_cmp++;
    if (out_data !== 9'o061) begin
      n_err++; $display("FAIL single_data: got %o need 061", out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (done_count !== 8'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_done: got dc=%0d ov=%b busy=%b need 1 0 0", done_count, out_valid, busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [20:0] cw;
    cw = 21'h0A5_5A3;
    out_ready = 1'b0;
    in_codeword = cw; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_timeout: got no out_valid need out_valid"); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== msg_of(cw) || dec_enable !== 1'b0 || done_count !== 8'd1) begin
        n_err++;
        $display("FAIL stall k=%0d: got ov=%b od=%o en=%b dc=%0d need 1 %o 0 1",
                 k, out_valid, out_data, dec_enable, done_count, msg_of(cw));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (done_count !== 8'd2) begin
      n_err++; $display("FAIL stall_done: got %0d need 2", done_count);
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] cws [4];
    logic [8:0]  got_v;
    int got;
    bit acc;
    cws[0] = 21'o1000001; cws[1] = 21'o2000002; cws[2] = 21'o3000003; cws[3] = 21'o4000004;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_codeword = cws[i]; in_valid = 1'b1;
      exp_q.push_back(msg_of(cws[i]));
      tick();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full: got in_ready=%b need 0", in_ready);
    end
    in_codeword = cws[3];
    exp_q.push_back(msg_of(cws[3]));
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold k=%0d: got in_ready=%b need 0", k, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 80 && got < 4; i++) begin
      if (out_valid) begin
        got_v = exp_q.pop_front();
        n_cmp++;
        if (out_data !== got_v) begin
          n_err++; $display("FAIL bp_order #%0d: got %o need %o", got, out_data, got_v);
        end
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got != 4 || done_count !== 8'd6) begin
      n_err++; $display("FAIL bp_count: got %0d msgs dc=%0d need 4 msgs dc=6", got, done_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] cx, cy;
    int t_first, t_second, seen;
    cx = 21'o5123456; cy = 21'o6654321;
    out_ready = 1'b1;
    in_codeword = cx; in_valid = 1'b1; tick();
    in_codeword = cy; tick();
    in_valid = 1'b0;
    seen = 0; t_first = -1; t_second = -1;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      if (out_valid) begin
        n_cmp++;
        if (out_data !== msg_of(seen == 0 ? cx : cy)) begin
          n_err++; $display("FAIL b2b_data #%0d: got %o need %o", seen, out_data, msg_of(seen == 0 ? cx : cy));
        end
        if (seen == 0) t_first = i; else t_second = i;
        seen++;
        tick();
        if (seen == 1) begin
          n_cmp++;
          if (dec_enable !== 1'b1) begin
            n_err++; $display("FAIL b2b_nobubble: got dec_enable=%b need 1", dec_enable);
          end
        end
      end else begin
        tick();
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (seen != 2 || t_second - t_first != L + 1) begin
      n_err++; $display("FAIL b2b_gap: got seen=%0d gap=%0d need 2 and %0d", seen, t_second - t_first, L + 1);
    end
    n_cmp++;
    if (done_count !== 8'd8) begin
      n_err++; $display("FAIL b2b_done: got %0d need 8", done_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    out_ready = 1'b1;
    in_codeword = 21'o7111111; in_valid = 1'b1; tick();
    in_codeword = 21'o7222222; tick();
    in_valid = 1'b0;
    tick(); tick();              // counter now 2
    n_cmp++;
    if (dec_enable !== 1'b1) begin
      n_err++; $display("FAIL rst_run_pre: got dec_enable=%b need 1", dec_enable);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({in_ready, dec_enable, out_valid, busy} !== 4'b1000 ||
        {dec_codeword, out_data, done_count} !== 38'd0) begin
      n_err++;
      $display("FAIL rst_run_post: got rdy=%b en=%b ov=%b busy=%b cw=%h od=%o dc=%0d need 1 0 0 0 0 0 0",
               in_ready, dec_enable, out_valid, busy, dec_codeword, out_data, done_count);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || dec_enable || busy) bad++;
      tick();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_run_discard: got %0d active cycles need 0", bad);
    end
  endtask

  task automatic test_wrap();
    int pushes, deliv;
    bit acc;
    out_ready = 1'b1;
    pushes = 0; deliv = 0;
    in_codeword = 21'd0; in_valid = 1'b1;
    for (int i = 0; i < 3000 && deliv < 256; i++) begin
      if (out_valid) begin
        deliv++;
        if (deliv == 256) begin
          n_cmp++;
          if (done_count !== 8'd255) begin
            n_err++; $display("FAIL wrap_255: got %0d need 255", done_count);
          end
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        pushes++;
        in_codeword = 21'(pushes * 4099);
        if (pushes == 256) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (deliv != 256 || done_count !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL wrap_zero: got deliv=%0d dc=%0d busy=%b need 256 0 0", deliv, done_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
